button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 113 +++++++++++
 tb/tb_button_conditioner.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchronizer, counter debounce and one-shot press/release pulses with optional auto-repeat
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit REP_EN = REPEAT_CYCLES > 0;

    typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} state_t;

    logic [NUM_BTN-1:0] s1, s2;

    // two-flop synchronizer on the asynchronous pins; only s2 is used downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t        state, state_n;
        logic [CW-1:0] cnt, cnt_n;
        logic [RW-1:0] rcnt, rcnt_n;
        logic          level, press, rel, press_n, rel_n;

        // debounce FSM; repeat counting runs while held but never fires on the release cycle
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            rcnt_n  = rcnt;
            press_n = 1'b0;
            rel_n   = 1'b0;
            case (state)
                RELEASED:
                    if (s2[i]) begin
                        state_n = CONFIRM_PRESS;
                        cnt_n   = CW'(1);
                    end
                CONFIRM_PRESS:
                    if (!s2[i]) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else if (cnt == CNT_DONE) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                        rcnt_n  = '0;
                        press_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                PRESSED:
                    if (!s2[i]) begin
                        state_n = CONFIRM_RELEASE;
                        cnt_n   = CW'(1);
                    end
                CONFIRM_RELEASE:
                    if (s2[i]) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else if (cnt == CNT_DONE) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                        rel_n   = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                default: state_n = RELEASED;
            endcase
            if (REP_EN && (state == PRESSED || state == CONFIRM_RELEASE) && state_n != RELEASED) begin
                press_n = rcnt == REP_LAST;
                rcnt_n  = press_n ? '0 : rcnt + 1'b1;
            end
        end

        // state, counters and registered outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= RELEASED;
                cnt   <= '0;
                rcnt  <= '0;
                level <= 1'b0;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                rcnt  <= rcnt_n;
                level <= state_n == PRESSED || state_n == CONFIRM_RELEASE;
                press <= press_n;
                rel   <= rel_n;
            end
        end

        assign btn_level[i]   = level;
        assign btn_press[i]   = press;
        assign btn_release[i] = rel;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, glitch rejection, auto-repeat, async reset and channel independence
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_raw = '0;
    logic [1:0] lvl, prs, rls, lvl_r, prs_r, rls_r;
    logic [0:0] lvl_d, prs_d, rls_d;
    int checks = 0, failures = 0, cyc = 0, both = 0;
    int p0[$], p1[$], r0[$], r1[$], pr0[$], rr0[$], pd[$];
    logic [1:0] pat [8];
    logic [1:0] rpat [7];
    int k;

    always #5 clk = ~clk;

    button_conditioner #(.NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl), .btn_press(prs), .btn_release(rls)
    );

    button_conditioner #(.NUM_BTN(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10)) dut_r (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl_r), .btn_press(prs_r), .btn_release(rls_r)
    );

    button_conditioner #(.NUM_BTN(1), .DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(0)) dut_d1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw[0:0]),
        .btn_level(lvl_d), .btn_press(prs_d), .btn_release(rls_d)
    );

    // log the edge index of every pulse, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (prs[0]) p0.push_back(cyc);
        if (prs[1]) p1.push_back(cyc);
        if (rls[0]) r0.push_back(cyc);
        if (rls[1]) r1.push_back(cyc);
        if (prs_r[0]) pr0.push_back(cyc);
        if (rls_r[0]) rr0.push_back(cyc);
        if (prs_d[0]) pd.push_back(cyc);
        if (|(prs & rls) || |(prs_r & rls_r) || |(prs_d & rls_d)) both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int nth(input int q[$], input int j);
        return (j < q.size()) ? q[j] : -1;
    endfunction

    task automatic set_raw(input logic [1:0] v);
        @(negedge clk);
        btn_raw = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        p0.delete(); p1.delete(); r0.delete(); r1.delete();
        pr0.delete(); rr0.delete(); pd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_raw = '0;
        wait_cyc(3);
        rst = 1'b0;
        clear_q();
    endtask

    initial begin
        pat  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
        rpat = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

        wait_cyc(2);
        check("reset_level", lvl, 0);
        check("reset_press", prs, 0);
        check("reset_release", rls, 0);
        rst = 1'b0;
        clear_q();

        set_raw(2'b01);
        k = cyc + 1;
        wait_cyc(20);
        check("clean_press_count", p0.size(), 1);
        check("clean_press_edge", nth(p0, 0), k + 6);
        check("clean_level0", lvl[0], 1);
        check("clean_no_release0", r0.size(), 0);
        check("clean_ch1_level", lvl[1], 0);
        check("clean_ch1_pulses", p1.size() + r1.size(), 0);
        check("d1_press_edge", nth(pd, 0), k + 3);
        check("d1_press_count", pd.size(), 1);

        do_reset();
        for (int j = 0; j < 8; j++) begin
            set_raw(pat[j]);
            if (j == 0) k = cyc + 1;
        end
        wait_cyc(20);
        check("bounce_press_count", p0.size(), 1);
        check("bounce_press_edge", nth(p0, 0), k + 13);
        check("bounce_no_release", r0.size(), 0);
        check("bounce_level", lvl[0], 1);

        clear_q();
        for (int j = 0; j < 7; j++) begin
            set_raw(rpat[j]);
            if (j == 0) k = cyc + 1;
        end
        check("blip_level_held", lvl[0], 1);
        check("blip_no_early_release", r0.size(), 0);
        wait_cyc(10);
        check("release_count", r0.size(), 1);
        check("release_edge", nth(r0, 0), k + 9);
        check("release_level", lvl[0], 0);
        check("blip_no_press", p0.size(), 0);

        do_reset();
        set_raw(2'b01);
        k = cyc + 1;
        wait_cyc(49);
        set_raw(2'b00);
        wait_cyc(15);
        check("repeat_count", pr0.size(), 5);
        for (int j = 0; j < 5; j++) check($sformatf("repeat_edge%0d", j), nth(pr0, j), k + 6 + 10 * j);
        check("repeat_release_count", rr0.size(), 1);
        check("repeat_release_edge", nth(rr0, 0), k + 56);
        check("norepeat_press_count", p0.size(), 1);

        do_reset();
        set_raw(2'b10);
        wait_cyc(10);
        set_raw(2'b11);
        wait_cyc(4);
        #3;
        check("async_pre_level", lvl, 2'b10);
        rst = 1'b1;
        #1;
        check("async_level", lvl, 0);
        check("async_press", prs, 0);
        check("async_release", rls, 0);
        wait_cyc(3);
        check("async_held_level", lvl, 0);
        rst = 1'b0;
        clear_q();
        k = cyc + 1;
        wait_cyc(12);
        check("postreset_press0_edge", nth(p0, 0), k + 6);
        check("postreset_press1_edge", nth(p1, 0), k + 6);
        check("postreset_press0_count", p0.size(), 1);

        do_reset();
        set_raw(2'b11);
        k = cyc + 1;
        wait_cyc(10);
        check("dual_press0_edge", nth(p0, 0), k + 6);
        check("dual_press1_edge", nth(p1, 0), k + 6);
        set_raw(2'b01);
        wait_cyc(10);
        check("dual_level0_kept", lvl[0], 1);
        check("dual_level1_dropped", lvl[1], 0);
        check("dual_release1_count", r1.size(), 1);
        check("dual_release0_count", r0.size(), 0);

        check("press_release_overlap", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
